// File: rtl/cg_write_arbiter_if.sv
// Requester/bank bus of the round-robin write arbiter.
// master = requester side (drives req/d_in), slave = arbiter side.
interface cg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) ();
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] d_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     en;
  logic [WIDTH-1:0]         d_out;
  logic                     cg_en;

  modport master (output req, d_in, input gnt, en, d_out, cg_en);
  modport slave  (input req, d_in, output gnt, en, d_out, cg_en);
endinterface

// File: rtl/cg_write_arbiter.sv
// Round-robin write arbiter with idle clock gating of the shared register bank.
// Optional macro CG_STATS_EN adds the saturating sleep_cycles counter output.
module cg_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CG_STATS_EN
  output logic [15:0] sleep_cycles,
`endif
  cg_write_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {SLEEP, WAKE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               en_q, en_d;
  logic [WIDTH-1:0]   d_out_q, d_out_d;
  logic               cg_en_q, cg_en_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
`ifdef CG_STATS_EN
  logic [15:0]        sleep_cycles_q, sleep_cycles_d;
`endif

  logic [NUM_REQ-1:0] elig;
  logic               win_vld;
  logic [PW-1:0]      win_idx;

  // A requester still holding its grant is skipped, so a held REQ becomes a new write one cycle later.
  always_comb begin
    elig    = bus.req & ~gnt_q;
    win_vld = 1'b0;
    win_idx = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && elig[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    en_d     = 1'b0;
    d_out_d  = d_out_q;
    cg_en_d  = cg_en_q;
    idle_d   = idle_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      SLEEP: begin
        cg_en_d = 1'b0;
        if (|bus.req) begin
          state_d = WAKE;
          cg_en_d = 1'b1;
        end
      end
      WAKE: begin
        state_d = ACTIVE;
        cg_en_d = 1'b1;
        idle_d  = '0;
      end
      ACTIVE: begin
        cg_en_d = 1'b1;
        if (!win_vld) begin
          // A request arriving on the expiring edge wins, so this branch only runs with no winner.
          if (idle_q == IW'(IDLE_CYCLES - 1)) begin
            state_d = SLEEP;
            cg_en_d = 1'b0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      default: state_d = SLEEP;
    endcase

    if (win_vld && (state_q != SLEEP)) begin
      gnt_d    = NUM_REQ'(1) << win_idx;
      en_d     = 1'b1;
      d_out_d  = bus.d_in[int'(win_idx)*WIDTH +: WIDTH];
      rr_ptr_d = win_idx;
    end
  end

`ifdef CG_STATS_EN
  always_comb begin
    sleep_cycles_d = sleep_cycles_q;
    if (state_q == SLEEP && sleep_cycles_q != 16'hFFFF) begin
      sleep_cycles_d = sleep_cycles_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SLEEP;
      gnt_q          <= '0;
      en_q           <= 1'b0;
      d_out_q        <= '0;
      cg_en_q        <= 1'b0;
      idle_q         <= '0;
      rr_ptr_q       <= PW'(NUM_REQ - 1);
`ifdef CG_STATS_EN
      sleep_cycles_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      en_q           <= en_d;
      d_out_q        <= d_out_d;
      cg_en_q        <= cg_en_d;
      idle_q         <= idle_d;
      rr_ptr_q       <= rr_ptr_d;
`ifdef CG_STATS_EN
      sleep_cycles_q <= sleep_cycles_d;
`endif
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.en    = en_q;
  assign bus.d_out = d_out_q;
  assign bus.cg_en = cg_en_q;
`ifdef CG_STATS_EN
  assign sleep_cycles = sleep_cycles_q;
`endif

endmodule

// File: tb/tb_cg_write_arbiter.sv
// Randomized and directed bench for cg_write_arbiter against a behavioural model.
// Define CG_STATS_EN to also cover the sleep_cycles counter.
module tb_cg_write_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IDLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cg_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
`ifdef CG_STATS_EN
  logic [15:0] sleep_cycles;
`endif

  cg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDLE_CYCLES(IDLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef CG_STATS_EN
    .sleep_cycles (sleep_cycles),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: mode 0 = asleep, 1 = waking, 2 = active
  int           mMode, mPtr, mIdle, mSleep;
  logic [N-1:0] mGnt;
  logic         mEn, mCg;
  logic [W-1:0] mDout;

  task automatic modelReset();
    mMode = 0; mPtr = N - 1; mIdle = 0; mSleep = 0;
    mGnt = '0; mEn = 1'b0; mCg = 1'b0; mDout = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic modelEdge();
    int win;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mPtr + k) % N;
      if (win < 0 && bus.req[idx] && !mGnt[idx]) win = idx;
    end
    if (mMode == 0 && mSleep < 65535) mSleep++;
    mGnt = '0;
    mEn  = 1'b0;
    if (mMode == 0) begin
      if (bus.req != 0) begin mMode = 1; mCg = 1'b1; end
    end else begin
      if (mMode == 1) begin
        mMode = 2; mIdle = 0;
      end else if (win < 0) begin
        mIdle++;
        if (mIdle == IDLE) begin mMode = 0; mCg = 1'b0; mIdle = 0; end
      end else begin
        mIdle = 0;
      end
      if (win >= 0) begin
        mGnt  = N'(1) << win;
        mEn   = 1'b1;
        mDout = bus.d_in[win*W +: W];
        mPtr  = win;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("gnt",   32'(bus.gnt),   32'(mGnt));
    checkVal("en",    32'(bus.en),    32'(mEn));
    checkVal("d_out", 32'(bus.d_out), 32'(mDout));
    checkVal("cg_en", 32'(bus.cg_en), 32'(mCg));
`ifdef CG_STATS_EN
    checkVal("sleep_cycles", 32'(sleep_cycles), 32'(mSleep));
`endif
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.d_in = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput();
  endtask

  task automatic setReq(input int i, input logic [W-1:0] d);
    bus.req[i] = 1'b1;
    bus.d_in[i*W +: W] = d;
  endtask

  // Protocol-following requesters: a granted requester drops REQ or offers new data.
  task automatic applyStimulus(input int prob);
    for (int i = 0; i < N; i++) begin
      if (mGnt[i]) begin
        if ($urandom_range(1) == 1) bus.d_in[i*W +: W] = W'($urandom);
        else bus.req[i] = 1'b0;
      end else if (!bus.req[i] && int'($urandom_range(15)) < prob) begin
        setReq(i, W'($urandom));
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.d_in = '0;

    $display("[TB] reset and idle");
    doReset();
    checkVal("rst_cg_en", 32'(bus.cg_en), 0);
    checkVal("rst_gnt",   32'(bus.gnt), 0);
    checkVal("rst_d_out", 32'(bus.d_out), 0);
    repeat (3) step();
    checkVal("idle_cg_en", 32'(bus.cg_en), 0);
    checkVal("idle_en",    32'(bus.en), 0);
`ifdef CG_STATS_EN
    checkVal("idle_sleep_cnt", 32'(sleep_cycles), 3);
`endif

    $display("[TB] single write from sleep");
    setReq(2, 8'h3C);
    step();
    checkVal("wake_cg_en", 32'(bus.cg_en), 1);
    checkVal("wake_gnt",   32'(bus.gnt), 0);
    step();
    checkVal("wr_gnt",   32'(bus.gnt), 32'h4);
    checkVal("wr_en",    32'(bus.en), 1);
    checkVal("wr_d_out", 32'(bus.d_out), 32'h3C);
    bus.req[2] = 1'b0;
    step();
    checkVal("hold_en",    32'(bus.en), 0);
    checkVal("hold_d_out", 32'(bus.d_out), 32'h3C);

    $display("[TB] round-robin");
    doReset();
    for (int i = 0; i < N; i++) setReq(i, W'($urandom));
    step();
    for (int g = 0; g < 8; g++) begin
      step();
      checkVal("rr_gnt", 32'(bus.gnt), 32'(1 << (g % N)));
      for (int i = 0; i < N; i++) if (mGnt[i]) bus.d_in[i*W +: W] = W'($urandom);
    end

    $display("[TB] idle gating");
    doReset();
    setReq(0, 8'h11);
    step(); step();
    checkVal("gate_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    repeat (3) step();
    checkVal("gate_cg_en_3", 32'(bus.cg_en), 1);
    step();
    checkVal("gate_cg_en_4", 32'(bus.cg_en), 0);
    setReq(0, 8'h22);
    step(); step();
    bus.req = '0;
    repeat (3) step();
    setReq(2, 8'h5A);
    step();
    checkVal("late_cg_en", 32'(bus.cg_en), 1);
    checkVal("late_gnt",   32'(bus.gnt), 32'h4);
    checkVal("late_d_out", 32'(bus.d_out), 32'h5A);
    bus.req = '0;
    repeat (6) step();

    $display("[TB] reset mid-write");
    doReset();
    setReq(1, 8'hA5);
    step(); step();
    checkVal("mid_gnt_before", 32'(bus.gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkVal("mid_gnt",   32'(bus.gnt), 0);
    checkVal("mid_en",    32'(bus.en), 0);
    checkVal("mid_d_out", 32'(bus.d_out), 0);
    checkVal("mid_cg_en", 32'(bus.cg_en), 0);
    bus.req = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    setReq(0, 8'h01);
    setReq(1, 8'h02);
    step(); step();
    checkVal("post_gnt",   32'(bus.gnt), 32'h1);
    checkVal("post_d_out", 32'(bus.d_out), 32'h01);
    bus.req[0] = 1'b0;
    step();
    checkVal("post_gnt2", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    repeat (6) step();

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 12; blk++) begin
      int prob;
      prob = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 1 : (blk % 4 == 2) ? 4 : 12;
      repeat (200) begin
        applyStimulus(prob);
        step();
      end
    end

`ifdef CG_STATS_EN
    $display("[TB] sleep counter saturation");
    doReset();
    repeat (70000) step();
    checkVal("sat_sleep_cnt", 32'(sleep_cycles), 32'hFFFF);
    repeat (5) step();
    checkVal("sat_sleep_hold", 32'(sleep_cycles), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
